fir_mem_arb: RTL and testbench
==============================

Name: fir_mem_arb

Overview:
- Arbiter for the FIR block's single-port coefficient/sample RAM.
- Two requesters share the one RAM port:
  - host: the APB bridge, which writes coefficients/samples and reads back results.
  - engine: the FIR datapath sequenced by fsm, which issues MAC-loop reads and result writes.
- Sits between the APB register block, the fsm-driven datapath and the RAM macro.
- Engine has priority while the filter is running; a starvation guard bounds host wait.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (1..4).
- MAX_STALL, 8, max consecutive cycles host may be denied while pracuje=1 (2..255).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- pracuje  in  1  FIR engine busy (from fsm)
- host_req  in  1  host access request, held until granted
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- eng_req, eng_we, eng_addr, eng_wdata  in  1/1/ADDR_W/DATA_W  engine request, same rules as host
- eng_gnt  out  1  engine access performed this cycle
- eng_rvalid  out  1  engine read data valid
- eng_rdata  out  DATA_W  engine read data
- ram_en, ram_we  out  1  RAM strobe / write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_en with ram_we=0

Behaviour:
- Grant timing:
  - Grant is combinational in the request cycle; at most one of host_gnt/eng_gnt is high.
  - ram_en equals host_gnt | eng_gnt; ram_we/addr/wdata are muxed from the granted requester; with no grant they are 0.
- Idle mode (pracuje=0): round-robin on register last_gnt.
  - Both requesting: grant the side not in last_gnt.
  - One requesting: grant it.
  - last_gnt updates on every grant.
- Busy mode (pracuje=1): engine wins unless stall_cnt == MAX_STALL, in which case host wins that cycle.
- stall_cnt (8 bit):
  - +1 each cycle host_req=1 and host_gnt=0, saturating at MAX_STALL.
  - Cleared on host_gnt or host_req=0.
- Read return:
  - Shift register of RD_LAT stages carrying {valid, owner}; stage 0 loads {ram_en & ~ram_we, granted side}.
  - host_rvalid/eng_rvalid are driven from the last stage by owner.
  - host_rdata and eng_rdata both pass ram_rdata; meaningful only while the matching rvalid is high.
- Requester rules:
  - Request and payload must stay stable until gnt; a request dropped before gnt is abandoned with no RAM access.
  - Back-to-back grants to the same side are allowed every cycle; reads pipeline with throughput 1.
- pracuje toggling mid-stream: mode changes take effect the same cycle; stall_cnt is kept.
- Reset mid-operation: on rst=1, all pending read returns are discarded and no rvalid is issued afterwards for them.
- Reset values:
  - Outputs: host_gnt, eng_gnt, host_rvalid, eng_rvalid, ram_en, ram_we = 0; ram_addr, ram_wdata = 0.
  - Registers: stall_cnt=0, last_gnt=host (engine wins the first tie), pipeline valids=0.
- Same-address host write and engine read in one cycle: only one is granted; the loser retries next cycle. No forwarding.

Optional Feature:
- Macro FIR_ARB_STATS_EN.
- Defined:
  - Extra ports stats_clr (in, 1) and host_stall_cnt (out, 16).
  - host_stall_cnt counts cycles with host_req=1 and host_gnt=0, saturating at 16'hFFFF.
  - stats_clr=1 zeroes it (clear wins over increment); reset value 0.
- Undefined: ports and counter do not exist; arbitration is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with both requests active -> all gnt/rvalid/ram_en = 0; first cycle after reset with both requesting -> eng_gnt=1.
- Idle round-robin: pracuje=0, both req held 6 cycles -> grants alternate E,H,E,H,E,H; ram_addr follows the granted address.
- Starvation guard: pracuje=1, MAX_STALL=4, both req held -> eng_gnt for 4 cycles, host_gnt on cycle 5, then engine again.
- Read routing: RD_LAT=2, engine reads addr 5 at t, host reads addr 9 at t+1 (pracuje=0), RAM returns 0x0AAA then 0x0BBB -> eng_rvalid at t+2 with 0x0AAA, host_rvalid at t+3 with 0x0BBB.
- Reset mid-read: RD_LAT=2, host read granted at t, rst=1 at t+1 -> host_rvalid never asserts.
- Stats (FIR_ARB_STATS_EN): pracuje=1, MAX_STALL=4, both req for 10 cycles -> host_stall_cnt=8; stats_clr pulse -> 0 next cycle.

Source files
------------

// File: rtl/fir_mem_arb.sv
// Single-port RAM arbiter for the FIR block: host (APB bridge) vs engine (MAC datapath), engine priority while busy.
// Latency: grant is combinational in the request cycle; read data returns with rvalid RD_LAT cycles after the grant.
// Backpressure: a requester holds req/payload until its gnt; the loser retries. Optional FIR_ARB_STATS_EN adds a host stall counter.
module fir_mem_arb #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_STALL = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FIR_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       host_stall_cnt,
`endif
    input  logic              pracuje,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [7:0] STALL_LIM = 8'(MAX_STALL);

    logic              r_last_eng;
    logic [7:0]        r_stall_cnt;
    logic [RD_LAT-1:0] r_pv;
    logic [RD_LAT-1:0] r_po;

    logic w_host_win;
    logic w_host_gnt;
    logic w_eng_gnt;
    logic w_rd;

    // Host wins a tie when busy only after MAX_STALL denials; when idle it alternates.
    always_comb begin
        w_host_win = pracuje ? (r_stall_cnt == STALL_LIM) : r_last_eng;
        w_host_gnt = ~rst & host_req & (~eng_req | w_host_win);
        w_eng_gnt  = ~rst & eng_req & ~w_host_gnt;
        w_rd       = (w_host_gnt & ~host_we) | (w_eng_gnt & ~eng_we);
    end

    assign host_gnt  = w_host_gnt;
    assign eng_gnt   = w_eng_gnt;
    assign ram_en    = w_host_gnt | w_eng_gnt;
    assign ram_we    = (w_host_gnt & host_we) | (w_eng_gnt & eng_we);
    assign ram_addr  = w_host_gnt ? host_addr  : (w_eng_gnt ? eng_addr  : '0);
    assign ram_wdata = w_host_gnt ? host_wdata : (w_eng_gnt ? eng_wdata : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_eng  <= 1'b0;
            r_stall_cnt <= '0;
            r_pv        <= '0;
            r_po        <= '0;
        end else begin
            if (w_host_gnt | w_eng_gnt)
                r_last_eng <= w_eng_gnt;
            if (host_req & ~w_host_gnt)
                r_stall_cnt <= (r_stall_cnt >= STALL_LIM) ? STALL_LIM : r_stall_cnt + 8'd1;
            else
                r_stall_cnt <= '0;
            // Owner bit: 1 = engine read in flight.
            r_pv[0] <= w_rd;
            r_po[0] <= w_eng_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_po[i] <= r_po[i-1];
            end
        end
    end

    assign host_rvalid = r_pv[RD_LAT-1] & ~r_po[RD_LAT-1];
    assign eng_rvalid  = r_pv[RD_LAT-1] &  r_po[RD_LAT-1];
    assign host_rdata  = ram_rdata;
    assign eng_rdata   = ram_rdata;

`ifdef FIR_ARB_STATS_EN
    logic [15:0] r_host_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || stats_clr)
            r_host_stall_cnt <= '0;
        else if (host_req && !w_host_gnt && r_host_stall_cnt != 16'hFFFF)
            r_host_stall_cnt <= r_host_stall_cnt + 16'd1;
    end

    assign host_stall_cnt = r_host_stall_cnt;
`endif

endmodule

// File: tb/tb_fir_mem_arb.sv
// Self-checking bench for fir_mem_arb: grant sequencing, RAM muxing and read-return routing via a scoreboard.
module tb_fir_mem_arb;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int RD_LAT = 2;
    localparam int MAX_STALL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pracuje;
    logic          host_req, host_we, eng_req, eng_we;
    logic [AW-1:0] host_addr, eng_addr;
    logic [DW-1:0] host_wdata, eng_wdata;
    logic          host_gnt, host_rvalid, eng_gnt, eng_rvalid;
    logic [DW-1:0] host_rdata, eng_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef FIR_ARB_STATS_EN
    logic          stats_clr;
    logic [15:0]   host_stall_cnt;
`endif

    fir_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst(rst),
`ifdef FIR_ARB_STATS_EN
        .stats_clr(stats_clr), .host_stall_cnt(host_stall_cnt),
`endif
        .pracuje(pracuje),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // RAM model with RD_LAT-cycle read pipeline
    logic          mem_init;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rp  [RD_LAT];
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    always @(posedge clk) begin
        rp[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
        if (mem_init) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= DW'(i * 3 + 1);
        end else if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = rp[RD_LAT-1];

    typedef struct {
        logic          eng;
        logic [DW-1:0] data;
        int            cyc;
    } sb_t;
    sb_t sb_q[$];

    always @(negedge clk) begin
        sb_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            chk("rv_missing", 32'(cyc), 32'(e.cyc));
        end
        if (host_rvalid || eng_rvalid) begin
            if (sb_q.size() == 0) begin
                chk("rv_unexpected", {30'd0, host_rvalid, eng_rvalid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rv_side", {30'd0, host_rvalid, eng_rvalid}, e.eng ? 32'd1 : 32'd2);
                chk("rv_data", e.eng ? 32'(eng_rdata) : 32'(host_rdata), 32'(e.data));
                chk("rv_lat", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drv(input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                       input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        eng_req = er;  eng_we = ew;  eng_addr = ea;  eng_wdata = ed;
    endtask

    // Check one cycle's grant against the expected winner, then advance.
    task automatic step(input logic eh, input logic ee);
        @(negedge clk);
        chk("host_gnt", 32'(host_gnt), 32'(eh));
        chk("eng_gnt", 32'(eng_gnt), 32'(ee));
        chk("ram_en", 32'(ram_en), 32'(eh | ee));
        if (eh) begin
            chk("ram_addr_h", 32'(ram_addr), 32'(host_addr));
            chk("ram_we_h", 32'(ram_we), 32'(host_we));
            if (host_we) begin
                chk("ram_wdata_h", 32'(ram_wdata), 32'(host_wdata));
                shadow[host_addr] = host_wdata;
            end else begin
                sb_q.push_back('{eng: 1'b0, data: shadow[host_addr], cyc: cyc + RD_LAT});
            end
        end else if (ee) begin
            chk("ram_addr_e", 32'(ram_addr), 32'(eng_addr));
            chk("ram_we_e", 32'(ram_we), 32'(eng_we));
            if (eng_we) begin
                chk("ram_wdata_e", 32'(ram_wdata), 32'(eng_wdata));
                shadow[eng_addr] = eng_wdata;
            end else begin
                sb_q.push_back('{eng: 1'b1, data: shadow[eng_addr], cyc: cyc + RD_LAT});
            end
        end else begin
            chk("ram_idle", {ram_we, 15'd0, ram_addr[AW-1:0] == '0 ? 16'd0 : 16'd1}, 32'd0);
            chk("ram_wdata_idle", 32'(ram_wdata), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    logic exp_h [10];
    initial begin
        for (int i = 0; i < (1<<AW); i++) shadow[i] = DW'(i * 3 + 1);
        rst = 1'b1;
        mem_init = 1'b1;
        pracuje = 1'b0;
`ifdef FIR_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        drv(1, 0, 10'd3, 16'h0, 1, 0, 10'd7, 16'h0);

        // Reset held with both requesting: nothing granted, no returns.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_rvalid", {30'd0, host_rvalid, eng_rvalid}, 32'd0);
            @(posedge clk);
            #1;
            mem_init = 1'b0;
            if (i == 0) begin
                @(negedge clk);
                chk("rst_gnt", {30'd0, host_gnt, eng_gnt}, 32'd0);
                chk("rst_ram_en", 32'(ram_en), 32'd0);
                @(posedge clk);
                #1;
            end
        end
        sb_q.delete();
        rst = 1'b0;

        // Idle round-robin: engine wins first tie, then alternates.
        for (int i = 0; i < 6; i++) step(i % 2 == 1, i % 2 == 0);

        // Host writes, then engine read at t and host read at t+1.
        drv(1, 1, 10'd5, 16'h0AAA, 0, 0, 10'd0, 16'h0);
        step(1, 0);
        drv(1, 1, 10'd9, 16'h0BBB, 0, 0, 10'd0, 16'h0);
        step(1, 0);
        drv(0, 0, 10'd0, 16'h0, 1, 0, 10'd5, 16'h0);
        step(0, 1);
        drv(1, 0, 10'd9, 16'h0, 0, 0, 10'd0, 16'h0);
        step(1, 0);
        drv(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0);
`ifdef FIR_ARB_STATS_EN
        stats_clr = 1'b1;
`endif
        step(0, 0);
`ifdef FIR_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        step(0, 0);
        step(0, 0);

        // Busy with both requesting: host gets through after MAX_STALL denials.
        pracuje = 1'b1;
        drv(1, 0, 10'd9, 16'h0, 1, 0, 10'd5, 16'h0);
        exp_h = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) step(exp_h[i], !exp_h[i]);
        drv(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0);
        step(0, 0);
`ifdef FIR_ARB_STATS_EN
        stats_clr = 1'b1;
        @(negedge clk);
        chk("stat_cnt", 32'(host_stall_cnt), 32'd8);
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        @(negedge clk);
        chk("stat_clr", 32'(host_stall_cnt), 32'd0);
        @(posedge clk);
        #1;
`endif

        // Busy, host alone: granted immediately.
        drv(1, 0, 10'd3, 16'h0, 0, 0, 10'd0, 16'h0);
        step(1, 0);

        // Mode flips to idle mid-stream: round-robin resumes from last grant (engine).
        drv(1, 0, 10'd9, 16'h0, 1, 0, 10'd7, 16'h0);
        step(0, 1);
        step(0, 1);
        pracuje = 1'b0;
        step(1, 0);
        drv(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0);

        // Reset one cycle after a host read grant: the return is discarded.
        drv(1, 0, 10'd9, 16'h0, 0, 0, 10'd0, 16'h0);
        step(1, 0);
        drv(0, 0, 10'd0, 16'h0, 0, 0, 10'd0, 16'h0);
        rst = 1'b1;
        sb_q.delete();
        step(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_rvalid", {30'd0, host_rvalid, eng_rvalid}, 32'd0);
            @(posedge clk);
            #1;
        end

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
